// File: rtl/board_cursor_datapath_if.sv
// rtl/board_cursor_datapath_if.sv - draw command channel between cursor datapath and box/disk renderer
interface board_cursor_datapath_if #(
  parameter int XP_W = 8,
  parameter int YP_W = 7
);
  logic            draw_req;
  logic            draw_ack;
  logic [XP_W-1:0] x_plot;
  logic [YP_W-1:0] y_plot;
  logic [1:0]      select;

  modport master (output draw_req, output x_plot, output y_plot, output select, input draw_ack);
  modport slave  (input draw_req, input x_plot, input y_plot, input select, output draw_ack);
endinterface

// File: rtl/board_cursor_datapath.sv
// rtl/board_cursor_datapath.sv - cursor position, side-to-move and erase/box/disk draw sequencer
module board_cursor_datapath #(
  parameter int BOARD_N  = 8,
  parameter int COORD_W  = 3,
  parameter int CELL_PX  = 13,
  parameter int ORIGIN_X = 9,
  parameter int ORIGIN_Y = 9,
  parameter int XP_W     = 8,
  parameter int YP_W     = 7,
  parameter int WRAP     = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    move_up,
  input  logic                    move_down,
  input  logic                    move_left,
  input  logic                    move_right,
  input  logic                    turn_side,
  input  logic                    place_disk,
  output logic [COORD_W-1:0]      x,
  output logic [COORD_W-1:0]      y,
  output logic                    side,
  output logic                    busy,
  board_cursor_datapath_if.master cmd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_BOX   = 2'd2;
  localparam logic [1:0] S_DISK  = 2'd3;

  localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  logic [5:0] btn_in, btn_cur, btn_prev, btn_ev;
  logic       armed;

  logic [1:0]         state, state_n;
  logic [COORD_W-1:0] cx, cy, ox, oy;
  logic [COORD_W-1:0] cx_n, cy_n, ox_n, oy_n;
  logic               pend, pend_n;
  logic               launch;

  logic               mv_ok;
  logic [COORD_W-1:0] mx, my;
  logic               place_ev, ack_ok, enter;
  logic [COORD_W-1:0] tcol, trow;
  logic [1:0]         tsel;

  assign btn_in   = {place_disk, turn_side, move_right, move_left, move_down, move_up};
  assign btn_ev   = btn_cur & ~btn_prev;
  assign place_ev = btn_ev[5];
  assign ack_ok   = cmd.draw_req & cmd.draw_ack;

  // The first sample after reset primes history with the live level, so a
  // button held through reset is not mistaken for a fresh press.
  always_ff @(posedge clock) begin
    if (resetn) begin
      btn_cur  <= '0;
      btn_prev <= '0;
      armed    <= 1'b0;
    end else begin
      btn_cur  <= btn_in;
      btn_prev <= armed ? btn_cur : btn_in;
      armed    <= 1'b1;
    end
  end

  always_comb begin
    mv_ok = 1'b0;
    mx    = cx;
    my    = cy;
    if (btn_ev[0]) begin
      if (cy != '0)      begin my = cy - ONE; mv_ok = 1'b1; end
      else if (WRAP != 0) begin my = LAST;     mv_ok = 1'b1; end
    end else if (btn_ev[1]) begin
      if (cy != LAST)    begin my = cy + ONE; mv_ok = 1'b1; end
      else if (WRAP != 0) begin my = '0;       mv_ok = 1'b1; end
    end else if (btn_ev[2]) begin
      if (cx != '0)      begin mx = cx - ONE; mv_ok = 1'b1; end
      else if (WRAP != 0) begin mx = LAST;     mv_ok = 1'b1; end
    end else if (btn_ev[3]) begin
      if (cx != LAST)    begin mx = cx + ONE; mv_ok = 1'b1; end
      else if (WRAP != 0) begin mx = '0;       mv_ok = 1'b1; end
    end
  end

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    ox_n    = ox;
    oy_n    = oy;
    pend_n  = pend;
    case (state)
      S_IDLE: begin
        if (mv_ok) begin
          ox_n    = cx;
          oy_n    = cy;
          cx_n    = mx;
          cy_n    = my;
          state_n = S_ERASE;
          pend_n  = pend | place_ev;
        end else if (place_ev || pend) begin
          state_n = S_DISK;
          pend_n  = 1'b0;
        end
      end
      S_ERASE: begin
        if (place_ev) pend_n = 1'b1;
        if (ack_ok)   state_n = S_BOX;
      end
      S_BOX: begin
        if (place_ev) pend_n = 1'b1;
        if (ack_ok) begin
          if (pend_n) begin
            state_n = S_DISK;
            pend_n  = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DISK: begin
        if (place_ev) pend_n = 1'b1;
        if (ack_ok)   state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Command fields are chosen from the post-edge state so they load on the
  // same edge the sequencer enters the new command state.
  always_comb begin
    enter = (state_n != state) && (state_n != S_IDLE);
    tcol  = (state_n == S_ERASE) ? ox_n : cx_n;
    trow  = (state_n == S_ERASE) ? oy_n : cy_n;
    case (state_n)
      S_ERASE: tsel = 2'd0;
      S_BOX:   tsel = 2'd1;
      S_DISK:  tsel = side ? 2'd2 : 2'd3;
      default: tsel = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state        <= S_IDLE;
      cx           <= '0;
      cy           <= '0;
      ox           <= '0;
      oy           <= '0;
      side         <= 1'b0;
      pend         <= 1'b0;
      launch       <= 1'b0;
      cmd.draw_req <= 1'b0;
      cmd.x_plot   <= '0;
      cmd.y_plot   <= '0;
      cmd.select   <= 2'd0;
    end else begin
      state <= state_n;
      cx    <= cx_n;
      cy    <= cy_n;
      ox    <= ox_n;
      oy    <= oy_n;
      pend  <= pend_n;
      if (btn_ev[4]) side <= ~side;
      if (enter) begin
        cmd.x_plot   <= XP_W'(32'(CELL_PX) * 32'(tcol) + 32'(ORIGIN_X));
        cmd.y_plot   <= YP_W'(32'(CELL_PX) * 32'(trow) + 32'(ORIGIN_Y));
        cmd.select   <= tsel;
        cmd.draw_req <= 1'b0;
        launch       <= 1'b1;
      end else if (launch) begin
        cmd.draw_req <= 1'b1;
        launch       <= 1'b0;
      end else if (ack_ok) begin
        cmd.draw_req <= 1'b0;
      end
    end
  end

  assign x    = cx;
  assign y    = cy;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_board_cursor_datapath.sv
// tb/tb_board_cursor_datapath.sv - bench for board_cursor_datapath across wrap, clamp and 6x6 builds
module tb_board_cursor_datapath;

  localparam logic [5:0] B_UP = 6'b000001, B_DN = 6'b000010, B_LF = 6'b000100;
  localparam logic [5:0] B_RT = 6'b001000, B_TURN = 6'b010000, B_PLACE = 6'b100000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic [5:0] btn [3];
  logic [2:0] xo [3];
  logic [2:0] yo [3];
  logic       side_o [3];
  logic       busy_o [3];
  logic       req_w [3];
  logic       ack_r [3];
  logic [1:0] sel_w [3];
  int         code_w [3];
  logic       hold_box [3];
  logic       seen_busy [3];
  int         cnt [3];

  int got_q [3][$];
  int exp_q [3][$];
  int nb [3] = '{8, 8, 6};
  int wr [3] = '{1, 0, 1};
  int mx [3], my [3], ms [3];

  int n_tests = 0;
  int n_fail  = 0;

  board_cursor_datapath_if cif0 ();
  board_cursor_datapath_if cif1 ();
  board_cursor_datapath_if cif2 ();

  board_cursor_datapath dut0 (
    .clock(clock), .resetn(resetn),
    .move_up(btn[0][0]), .move_down(btn[0][1]), .move_left(btn[0][2]), .move_right(btn[0][3]),
    .turn_side(btn[0][4]), .place_disk(btn[0][5]),
    .x(xo[0]), .y(yo[0]), .side(side_o[0]), .busy(busy_o[0]), .cmd(cif0));

  board_cursor_datapath #(.WRAP(0)) dut1 (
    .clock(clock), .resetn(resetn),
    .move_up(btn[1][0]), .move_down(btn[1][1]), .move_left(btn[1][2]), .move_right(btn[1][3]),
    .turn_side(btn[1][4]), .place_disk(btn[1][5]),
    .x(xo[1]), .y(yo[1]), .side(side_o[1]), .busy(busy_o[1]), .cmd(cif1));

  board_cursor_datapath #(.BOARD_N(6)) dut2 (
    .clock(clock), .resetn(resetn),
    .move_up(btn[2][0]), .move_down(btn[2][1]), .move_left(btn[2][2]), .move_right(btn[2][3]),
    .turn_side(btn[2][4]), .place_disk(btn[2][5]),
    .x(xo[2]), .y(yo[2]), .side(side_o[2]), .busy(busy_o[2]), .cmd(cif2));

  assign req_w[0] = cif0.draw_req;
  assign req_w[1] = cif1.draw_req;
  assign req_w[2] = cif2.draw_req;
  assign sel_w[0] = cif0.select;
  assign sel_w[1] = cif1.select;
  assign sel_w[2] = cif2.select;
  assign code_w[0] = int'(cif0.x_plot) * 1024 + int'(cif0.y_plot) * 4 + int'(cif0.select);
  assign code_w[1] = int'(cif1.x_plot) * 1024 + int'(cif1.y_plot) * 4 + int'(cif1.select);
  assign code_w[2] = int'(cif2.x_plot) * 1024 + int'(cif2.y_plot) * 4 + int'(cif2.select);
  assign cif0.draw_ack = ack_r[0];
  assign cif1.draw_ack = ack_r[1];
  assign cif2.draw_ack = ack_r[2];

  // Renderer stand-in: acknowledges in the second cycle of each request and logs the command.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_o[i]) seen_busy[i] = 1'b1;
      if (req_w[i] && !ack_r[i]) begin
        if (!(hold_box[i] && sel_w[i] == 2'd1)) begin
          cnt[i]++;
          if (cnt[i] == 2) begin
            ack_r[i] = 1'b1;
            got_q[i].push_back(code_w[i]);
          end
        end
      end else begin
        ack_r[i] = 1'b0;
        cnt[i]   = 0;
      end
    end
  end

  function automatic int code(input int c, input int r, input int sel);
    return ((13 * c + 9) % 256) * 1024 + ((13 * r + 9) % 128) * 4 + sel;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one isolated button pulse applied to an idle board.
  task automatic model_step(input int i, input logic [5:0] b);
    int nx, ny, dx, dy;
    dx = 0; dy = 0;
    if (b[4]) ms[i] ^= 1;
    if (b[0]) dy = -1;
    else if (b[1]) dy = 1;
    else if (b[2]) dx = -1;
    else if (b[3]) dx = 1;
    if (dx != 0 || dy != 0) begin
      nx = mx[i] + dx;
      ny = my[i] + dy;
      if (wr[i] != 0) begin
        nx = (nx + nb[i]) % nb[i];
        ny = (ny + nb[i]) % nb[i];
      end
      if (nx >= 0 && nx < nb[i] && ny >= 0 && ny < nb[i]) begin
        exp_q[i].push_back(code(mx[i], my[i], 0));
        exp_q[i].push_back(code(nx, ny, 1));
        mx[i] = nx;
        my[i] = ny;
      end
    end
    if (b[5]) exp_q[i].push_back(code(mx[i], my[i], ms[i] != 0 ? 2 : 3));
  endtask

  task automatic pulse(input logic [2:0] mask, input logic [5:0] b);
    @(negedge clock);
    for (int i = 0; i < 3; i++) if (mask[i]) btn[i] = b;
    @(negedge clock);
    for (int i = 0; i < 3; i++) btn[i] = '0;
  endtask

  task automatic settle(input string tag);
    int k;
    k = 0;
    repeat (3) @(negedge clock);
    while (k < 60 && (busy_o[0] || busy_o[1] || busy_o[2] || req_w[0] || req_w[1] || req_w[2])) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_settle"}, int'(k < 60), 1);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(xo[i]), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), int'(yo[i]), my[i]);
      chk($sformatf("%s_side%0d", tag, i), int'(side_o[i]), ms[i]);
      chk($sformatf("%s_ncmd%0d", tag, i), got_q[i].size(), exp_q[i].size());
      for (int j = 0; j < got_q[i].size() && j < exp_q[i].size(); j++)
        chk($sformatf("%s_cmd%0d_%0d", tag, i, j), got_q[i][j], exp_q[i][j]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0; my[i] = 0; ms[i] = 0;
      got_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    clear_model();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int k, op;
    logic [5:0] dirs [4];
    logic [5:0] seq [5];
    dirs = '{B_UP, B_DN, B_LF, B_RT};
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn[i] = '0; ack_r[i] = 1'b0; hold_box[i] = 1'b0; seen_busy[i] = 1'b0; cnt[i] = 0;
    end
    do_reset();

    chk("rst_x", int'(xo[0]), 0);
    chk("rst_y", int'(yo[0]), 0);
    chk("rst_side", int'(side_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_req", int'(req_w[0]), 0);
    chk("rst_sel", int'(cif0.select), 0);
    chk("rst_xplot", int'(cif0.x_plot), 0);
    chk("rst_yplot", int'(cif0.y_plot), 0);

    pulse(3'b111, B_RT);
    for (int i = 0; i < 3; i++) model_step(i, B_RT);
    settle("right");
    check_all("right");
    chk("right_n", got_q[0].size(), 2);
    if (got_q[0].size() == 2) begin
      chk("right_erase", got_q[0][0], 9 * 1024 + 9 * 4 + 0);
      chk("right_box", got_q[0][1], 22 * 1024 + 9 * 4 + 1);
    end
    chk("right_busy", int'(busy_o[0]), 0);

    do_reset();
    for (int i = 0; i < 3; i++) seen_busy[i] = 1'b0;
    pulse(3'b111, B_UP);
    for (int i = 0; i < 3; i++) model_step(i, B_UP);
    settle("wrap_up");
    check_all("wrap_up");
    chk("wrap_y", int'(yo[0]), 7);
    if (got_q[0].size() == 2) chk("wrap_box_yplot", (got_q[0][1] >> 2) & 127, 100);
    chk("clamp_y", int'(yo[1]), 0);
    chk("clamp_ncmd", got_q[1].size(), 0);
    chk("clamp_busy_seen", int'(seen_busy[1]), 0);
    chk("wrap6_y", int'(yo[2]), 5);

    @(negedge clock);
    for (int i = 0; i < 3; i++) btn[i] = B_UP;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 3; i++) btn[i] = '0;
    for (int i = 0; i < 3; i++) model_step(i, B_UP);
    settle("hold");
    check_all("hold");

    pulse(3'b111, B_UP | B_LF);
    for (int i = 0; i < 3; i++) model_step(i, B_UP | B_LF);
    settle("prio");
    check_all("prio");
    chk("prio_x", int'(xo[0]), 0);

    // Place, turn, a second place and a down move all land while dut0 is busy.
    seq = '{B_RT, B_PLACE, B_TURN, B_PLACE, B_DN};
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      btn[0] = seq[s];
    end
    @(negedge clock);
    btn[0] = '0;
    ms[0] ^= 1;
    model_step(0, B_RT | B_PLACE);
    settle("pend");
    check_all("pend");
    chk("pend_n", got_q[0].size() - exp_q[0].size(), 0);
    if (got_q[0].size() > 0) chk("pend_disk_sel", got_q[0][got_q[0].size() - 1] & 3, 2);

    hold_box[0] = 1'b1;
    pulse(3'b001, B_RT);
    k = 0;
    while (k < 40 && !(req_w[0] && sel_w[0] == 2'd1)) begin
      @(negedge clock);
      k++;
    end
    chk("box_reached", int'(k < 40), 1);
    for (int i = 0; i < 3; i++) btn[i] = B_RT;
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_mid_req", int'(req_w[0]), 0);
    chk("rst_mid_x", int'(xo[0]), 0);
    chk("rst_mid_y", int'(yo[0]), 0);
    chk("rst_mid_side", int'(side_o[0]), 0);
    chk("rst_mid_busy", int'(busy_o[0]), 0);
    @(negedge clock);
    resetn = 1'b0;
    hold_box[0] = 1'b0;
    clear_model();
    repeat (10) @(negedge clock);
    for (int i = 0; i < 3; i++) btn[i] = '0;
    settle("held_rst");
    check_all("held_rst");

    for (int m = 0; m < 6; m++) begin
      pulse(3'b111, B_RT);
      for (int i = 0; i < 3; i++) model_step(i, B_RT);
      settle("n6");
    end
    check_all("n6");
    chk("n6_x", int'(xo[2]), 0);
    begin
      int xp [6];
      xp = '{22, 35, 48, 61, 74, 9};
      if (got_q[2].size() == 12)
        for (int m = 0; m < 6; m++) chk($sformatf("n6_xplot%0d", m), got_q[2][2 * m + 1] >> 10, xp[m]);
    end

    for (int r = 0; r < 40; r++) begin
      logic [5:0] b;
      op = int'($urandom_range(0, 6));
      if (op < 4)       b = dirs[op];
      else if (op == 4) b = B_PLACE;
      else if (op == 5) b = B_TURN;
      else              b = dirs[$urandom_range(0, 3)] | B_PLACE;
      pulse(3'b111, b);
      for (int i = 0; i < 3; i++) model_step(i, b);
      settle("rnd");
      check_all($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_cursor_datapath.md
Name: board_cursor_datapath

Overview:
- Parametrised cursor/board datapath for the Othello VGA front end. It generalises the fixed 8x8 cursor datapath to any board size, cell pitch and origin, with a selectable edge mode (wrap or clamp).
- It owns cursor position, previous position and side-to-move, and issues drawing commands to the box/disk renderer.
- Commands use a sequenced req/ack handshake instead of level-held plot strobes.

Parameters:
BOARD_N, 8, cells per row/column (2..2^COORD_W)
COORD_W, 3, width of cell coordinates
CELL_PX, 13, pixel pitch of one cell
ORIGIN_X, 9, pixel x of cell (0,0)
ORIGIN_Y, 9, pixel y of cell (0,0)
XP_W, 8, width of x_plot
YP_W, 7, width of y_plot
WRAP, 1, 1 = cursor wraps at board edge, 0 = cursor clamps at edge

Ports:
clock  in  1  system clock
resetn  in  1  synchronous reset, active-high (kept under the codebase's existing name)
move_up  in  1  level request, acted on at rising edge
move_down  in  1  level request, acted on at rising edge
move_left  in  1  level request, acted on at rising edge
move_right  in  1  level request, acted on at rising edge
turn_side  in  1  level request; side toggles on its rising edge
place_disk  in  1  level request; disk draw on its rising edge
draw_ack  in  1  renderer finished current command
x  out  COORD_W  current cursor column
y  out  COORD_W  current cursor row
side  out  1  side to move
draw_req  out  1  command valid
x_plot  out  XP_W  pixel x of command cell
y_plot  out  YP_W  pixel y of command cell
select  out  2  0 = empty cell, 1 = cursor box, 2 = disk side 1, 3 = disk side 0
busy  out  1  sequencer not IDLE

Behaviour:
Reset (resetn high at a clock edge):
- x, y, old position, side: 0. State: IDLE. draw_req, busy, select, x_plot, y_plot: 0.
- Pending flag and edge-detect history registers: 0. A level held high through reset does not count as an edge after reset.
- Reset mid-handshake aborts the command: draw_req is low the cycle after reset.

Edge detection:
- Each request input is registered. An event is input high while the previous sample was low.
- Each event lasts exactly 1 cycle.

Moves:
- Priority: up > down > left > right. Only the highest-priority move event in a cycle is used.
- up decrements y, down increments y, left decrements x, right increments x.
- WRAP=1: the result is modulo BOARD_N, so 0 - 1 gives BOARD_N - 1 and BOARD_N - 1 + 1 gives 0. This must be correct for non-power-of-2 BOARD_N.
- WRAP=0: a move off the edge is discarded. Position is unchanged and no draw is issued.
- A move is accepted only in IDLE. An accepted move sets old <= curr and updates curr in the same edge, then enters ERASE.
- Move events while busy are dropped.

turn_side:
- Toggles side on its event, in any state, with 1-cycle latency.
- The disk colour is sampled on entry to DISK.

place_disk:
- Event in IDLE with no move event: enter DISK.
- Event while busy, or together with an accepted move: set pending. Further events while pending is set are dropped; depth is 1.

Sequencer states:
- IDLE -> ERASE on an accepted move. IDLE -> DISK on a place_disk event or pending. Pending is cleared on entry to DISK.
- ERASE: command (old, select 0). On ack -> BOX.
- BOX: command (curr, select 1). On ack -> DISK if pending, else IDLE.
- DISK: command (curr, select 2 if side=1, else 3). On ack -> IDLE.

Handshake:
- On state entry, x_plot, y_plot and select are registered and draw_req rises 1 cycle after the transition edge.
- Command outputs stay stable while draw_req is high.
- draw_ack is sampled only while draw_req is high. ack in cycle t drops draw_req at t+1.
- The next command's draw_req rises at t+2 at the earliest, so draw_req is low for at least 1 cycle between commands.
- draw_ack while draw_req is low is ignored.
- busy = (state != IDLE).

Arithmetic:
- x_plot = CELL_PX*col + ORIGIN_X, computed at full width, then truncated to XP_W. y_plot is computed the same way with row, ORIGIN_Y and YP_W.
- Default corners: cell 0 gives 9. Cell 7 gives 100.
- The combinational path from curr/old to the plot registers must have no latches.

Test Plan:
- Reset, then pulse move_right with ack returned 2 cycles after each req -> x=1, y=0. Commands in order: (9,9,sel 0), then (22,9,sel 1). busy returns to 0.
- WRAP=1: from (0,0) pulse move_up -> y=7, BOX command at y_plot=100. WRAP=0: same stimulus -> y stays 0, no draw_req, busy stays 0.
- Hold move_up high for 20 cycles -> exactly one move. Raise move_up and move_left in the same cycle -> only y changes.
- During ERASE wait, pulse place_disk, then toggle turn_side once (side 0->1) -> sequence is ERASE, BOX, then DISK with select 2.
- A second place_disk while pending is already set is dropped, and a move while busy is dropped -> exactly one DISK and no position change.
- Assert resetn while draw_req=1 in BOX -> next cycle draw_req=0, x=y=0, side=0, busy=0. Holding move_right across reset release produces no move.
- BOARD_N=6, WRAP=1: right x6 from x=0 -> x=0 after the sixth move. Intermediate x_plot values: 22, 35, 48, 61, 74, 9.
